// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide sequencer: 32-step shift-add / restoring divide, 33-cycle latency.
// Optional MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle combinational product latched at start.
module muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_ex,
  input  logic [1:0]      op_ex,
  input  logic [XLEN-1:0] src_a_ex,
  input  logic [XLEN-1:0] src_b_ex,
  input  logic            flush,
  input  logic            hilo_read_id,
  input  logic            mthi_we,
  input  logic            mtlo_we,
  input  logic [XLEN-1:0] mt_data,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opb_q;
  logic              is_div_q, neg_a_q, neg_b_q, dz_q, done_q;
  logic [XLEN-1:0]   hi_q, lo_q;

  logic              signed_op, neg_a, neg_b, is_div;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

  always_comb begin
    signed_op = ~op_ex[0];
    is_div    = op_ex[1];
    neg_a     = signed_op & src_a_ex[XLEN-1];
    neg_b     = signed_op & src_b_ex[XLEN-1];
    mag_a     = neg_a ? -src_a_ex : src_a_ex;
    mag_b     = neg_b ? -src_b_ex : src_b_ex;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}; add then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
  end

  // Divide: acc = {remainder, dividend/quotient}; trial-subtract the shifted remainder.
  always_comb begin
    div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opb_q};
    if (div_diff[XLEN+1])
      div_next = {acc_q[2*XLEN-2:0], 1'b0};
    else
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_hi   = prod_fix[2*XLEN-1:XLEN];
    fix_lo   = prod_fix[XLEN-1:0];
    if (is_div_q) begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
      // With a zero divisor the remainder is |a|; restoring its sign returns src_a exactly.
      if (dz_q) fix_lo = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mthi_we) hi_q <= mt_data;
          if (mtlo_we) lo_q <= mt_data;
          if (start_ex && !flush) begin
            is_div_q <= is_div;
            neg_a_q  <= neg_a;
            neg_b_q  <= neg_b;
            dz_q     <= is_div && (src_b_ex == '0);
            cnt_q    <= CNT_W'(XLEN);
            state_q  <= CALC;
            if (is_div) begin
              acc_q <= {{XLEN{1'b0}}, mag_a};
              opb_q <= mag_b;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              acc_q   <= {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
              state_q <= FIX;
`else
              acc_q <= {{XLEN{1'b0}}, mag_b};
`endif
              opb_q <= mag_a;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= is_div_q ? div_next : mul_next;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          if (!flush) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign stall_req = busy & (start_ex | hilo_read_id | mthi_we | mtlo_we);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
